fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction-fetch stage directly downstream of the program counter. Takes the current PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. Presents the buffered instructions to decode over a valid/ready handshake. Drives pc_advance back to the next-PC logic. Supports flush on redirect, discarding responses still in flight.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
pc_address  in  XLEN  current PC from pc register
pc_advance  out  1  PC consumed this cycle; next-PC logic steps PC (+4 or target)
flush  in  1  redirect: discard queue and in-flight fetches
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (= pc_address)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  instruction returned (in order, latency >= 1)
imem_rsp_data  in  XLEN  returned instruction
id_valid  out  1  instruction available to decode
id_instr  out  XLEN  instruction at queue head
id_pc  out  XLEN  PC of id_instr
id_ready  in  1  decode accepts

Behaviour:
- State: entry[DEPTH] {pc, instr, filled}; head, tail, fill pointers (log2 DEPTH bits, wrap modulo DEPTH); count, outstanding, drop_cnt (log2 DEPTH + 1 bits).
- Reset (rst_n low, async): pointers, counters, all filled bits = 0. Outputs while in reset: imem_req_valid=0, pc_advance=0, id_valid=0, imem_req_addr=0, id_instr=0, id_pc=0.
- imem_req_valid = !flush && count < DEPTH && drop_cnt == 0. imem_req_addr = pc_address (combinational).
- Issue = imem_req_valid && imem_req_ready. pc_advance = issue (combinational, same cycle). On issue: entry[tail].pc <= pc_address, filled <= 0, tail++, count++, outstanding++.
- Response when drop_cnt > 0: data discarded, drop_cnt--, outstanding--.
- Response when drop_cnt == 0: entry[fill].instr <= imem_rsp_data, filled <= 1, fill++, outstanding--.
- id_valid = !flush && count > 0 && entry[head].filled. id_instr/id_pc = entry[head] (combinational read). Pop = id_valid && id_ready: head++, count--.
- Simultaneous events: issue + pop in one cycle leaves count unchanged. Issue + response in one cycle leaves outstanding unchanged. Response fill and pop of the same entry cannot coincide, because filled is registered.
- Latency: request accepted in cycle N with 1-cycle memory -> response in N+1 -> id_valid in N+2. Full throughput of 1 instr/cycle when id_ready=1.
- Full (count == DEPTH): no issue and pc_advance=0, so the PC holds. Empty or head unfilled: id_valid=0.
- Flush (cycle F): imem_req_valid=0, pc_advance=0, id_valid=0 during F; any response arriving in F is discarded. At the end of F:
  - head=tail=fill=0, count=0, all filled=0;
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0);
  - outstanding <= the same value.
  - The upstream logic loads the redirect target into the PC in cycle F. Fetching resumes once drop_cnt==0, which can be as early as cycle F+1.
- Invariant: outstanding <= count <= DEPTH outside flush recovery.
- imem_rsp_valid with outstanding==0 is a protocol violation: the response is ignored, no counter change, and the bench flags it with an assertion.
- Reset asserted mid-operation clears everything immediately. In-flight responses after reset are the memory's responsibility; the memory is reset by the same rst_n.

Test Plan:
- Stream: 1-cycle mem, ready=1, id_ready=1, PC 0x0,0x4,0x8 with instrs 0x00000013,0x00500093,0x00A00113 -> first id_valid 2 cycles after first issue; id_pc/id_instr pairs in order; pc_advance high every cycle.
- Backpressure: id_ready=0 -> after 4 issues (PC 0x0..0xC) imem_req_valid=0 and pc_advance=0 with PC held at 0x10. Raise id_ready -> entries drain in order at 1/cycle, and issue resumes the cycle after the first pop.
- Memory stall: imem_req_ready=0 for 3 cycles -> pc_advance=0 and imem_req_addr stable; no queue change.
- Flush with 2 in flight (3-cycle mem): flush, PC -> 0x100 -> next 2 responses discarded (never on id_instr); first id_pc after flush = 0x100.
- Flush coincident with response: 1 in flight, rsp and flush in the same cycle -> response discarded; drop_cnt=0; issue of 0x200 in the next cycle.
- Async reset: drop rst_n mid-burst, between clock edges -> id_valid, imem_req_valid, pc_advance go 0 immediately. After release, fetching restarts cleanly from the PC and count=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Purpose: in-order instruction fetch; issues PC requests to imem and queues returned instrs with their PCs.
// Latency: request accepted in cycle N with 1-cycle memory -> id_valid in N+2; sustains 1 instr/cycle.
// Backpressure: id_ready low fills the queue; when DEPTH entries are reserved, issue and pc_advance stop.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   pc_address / pc_advance       current PC in; pulse back to next-PC logic when that PC is issued
//   flush                         redirect: empties the queue and discards responses still in flight
//   imem_req_* / imem_rsp_*       request handshake to instruction memory, in-order response stream
//   id_valid/id_instr/id_pc/id_ready  queue head presented to decode
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_address,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Queue storage. An entry is reserved at issue (pc written) and becomes
    // visible to decode once its instruction has been written (filled).
    logic [XLEN-1:0]  entry_pc    [DEPTH];
    logic [XLEN-1:0]  entry_instr [DEPTH];
    logic [DEPTH-1:0] entry_filled;

    logic [PTR_W-1:0] head;     // oldest entry, presented to decode
    logic [PTR_W-1:0] tail;     // next entry to reserve on issue
    logic [PTR_W-1:0] fill;     // next entry to receive a response
    logic [CNT_W-1:0] count;    // reserved entries
    logic [CNT_W-1:0] outstanding; // requests issued, response not yet seen
    logic [CNT_W-1:0] drop_cnt; // stale responses still to discard after a flush

    logic issue;
    logic pop;
    logic rsp_ok;
    logic rsp_keep;

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign imem_req_valid = rst_n && !flush && (count < DEPTH_C) && (drop_cnt == '0);
    assign imem_req_addr  = rst_n ? pc_address : '0;
    assign issue          = imem_req_valid && imem_req_ready;
    assign pc_advance     = issue;

    assign id_valid = rst_n && !flush && (count != '0) && entry_filled[head];
    assign id_instr = rst_n ? entry_instr[head] : '0;
    assign id_pc    = rst_n ? entry_pc[head]    : '0;
    assign pop      = id_valid && id_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
    // Responses still owed to fetches cancelled by a flush are discarded.
    assign rsp_keep = rsp_ok && (drop_cnt == '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            fill         <= '0;
            count        <= '0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            entry_filled <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            fill         <= '0;
            count        <= '0;
            entry_filled <= '0;
            // Everything still in flight (less a response landing this cycle)
            // belongs to the old path and must be dropped when it returns.
            outstanding  <= outstanding - CNT_W'(rsp_ok);
            drop_cnt     <= outstanding - CNT_W'(rsp_ok);
        end else begin
            tail        <= tail + PTR_W'(issue);
            head        <= head + PTR_W'(pop);
            count       <= count + CNT_W'(issue) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_ok);
            if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (rsp_keep) begin
                fill <= fill + PTR_W'(1);
            end
            // tail never equals fill while a response is pending, so the
            // clear on issue and the set on fill never target the same bit.
            if (issue) begin
                entry_filled[tail] <= 1'b0;
            end
            if (rsp_keep) begin
                entry_filled[fill] <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; filled gates its visibility.
    always_ff @(posedge clk) begin
        if (issue) begin
            entry_pc[tail] <= pc_address;
        end
        if (rsp_keep) begin
            entry_instr[fill] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose: directed bench for fetch_queue with a behavioural in-order memory and PC model.
// Latency: memory returns responses a programmable 1..3 cycles after acceptance.
// Backpressure: imem_req_ready and id_ready are driven directly by the directed steps.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_address;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int errors = 0;
    int checks = 0;
    int inflight = 0;

    // Memory pipeline: stage k holds a request accepted k cycles ago.
    logic        mem_v [1:3];
    logic [31:0] mem_a [1:3];
    logic [1:0]  lat;

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_address     (pc_address),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within 50000 time units");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0050_0093;
            32'h0000_0008: return 32'h00A0_0113;
            default:       return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mem_clear();
        for (int i = 1; i <= 3; i++) begin
            mem_v[i] = 1'b0;
            mem_a[i] = 32'h0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inflight       = 0;
    endtask

    // One clock: sample handshakes mid-cycle, cross the edge, then update
    // the memory pipeline and the PC model, and let the DUT settle.
    task automatic tick();
        logic        iss;
        logic        adv;
        logic [31:0] addr_s;
        #1;
        iss    = imem_req_valid && imem_req_ready;
        adv    = pc_advance;
        addr_s = imem_req_addr;
        if (imem_rsp_valid) begin
            assert (inflight > 0)
            else $error("protocol: response presented with no request outstanding");
        end
        @(posedge clk);
        #1;
        if (imem_rsp_valid && inflight > 0) inflight--;
        if (iss) inflight++;
        for (int i = 3; i > 1; i--) begin
            mem_v[i] = mem_v[i-1];
            mem_a[i] = mem_a[i-1];
        end
        mem_v[1] = iss;
        mem_a[1] = addr_s;
        if (adv) pc_address = pc_address + 32'd4;
        imem_rsp_valid = mem_v[lat];
        imem_rsp_data  = mem_v[lat] ? mem_word(mem_a[lat]) : 32'h0;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        pc_address     = 32'h55;
        lat            = 2'd1;
        mem_clear();
        #2;
        // Reset state
        chk("rst_req_valid",  imem_req_valid, 32'd0);
        chk("rst_pc_advance", pc_advance,     32'd0);
        chk("rst_id_valid",   id_valid,       32'd0);
        chk("rst_req_addr",   imem_req_addr,  32'd0);
        chk("rst_id_instr",   id_instr,       32'd0);
        chk("rst_id_pc",      id_pc,          32'd0);

        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        pc_address = 32'h0;
        #1;

        // Stream with 1-cycle memory
        chk("s0_req_valid",  imem_req_valid, 32'd1);
        chk("s0_pc_advance", pc_advance,     32'd1);
        chk("s0_req_addr",   imem_req_addr,  32'h0);
        chk("s0_id_valid",   id_valid,       32'd0);
        tick();
        chk("s1_id_valid",   id_valid,       32'd0);
        chk("s1_req_addr",   imem_req_addr,  32'h4);
        chk("s1_pc_advance", pc_advance,     32'd1);
        tick();
        chk("s2_id_valid",   id_valid,       32'd1);
        chk("s2_id_pc",      id_pc,          32'h0);
        chk("s2_id_instr",   id_instr,       32'h0000_0013);
        chk("s2_pc_advance", pc_advance,     32'd1);
        tick();
        chk("s3_id_pc",      id_pc,          32'h4);
        chk("s3_id_instr",   id_instr,       32'h0050_0093);
        chk("s3_pc_advance", pc_advance,     32'd1);
        tick();
        chk("s4_id_pc",      id_pc,          32'h8);
        chk("s4_id_instr",   id_instr,       32'h00A0_0113);
        chk("s4_pc_advance", pc_advance,     32'd1);

        // Memory stall for 3 cycles: PC held at 0x10
        imem_req_ready = 1'b0;
        #1;
        chk("st0_pc_advance", pc_advance,    32'd0);
        chk("st0_req_addr",   imem_req_addr, 32'h10);
        tick();
        chk("st1_pc_advance", pc_advance,    32'd0);
        chk("st1_req_addr",   imem_req_addr, 32'h10);
        chk("st1_id_pc",      id_pc,         32'hC);
        chk("st1_id_instr",   id_instr,      32'hC0DE_000C);
        tick();
        chk("st2_pc_advance", pc_advance,    32'd0);
        chk("st2_req_addr",   imem_req_addr, 32'h10);
        chk("st2_id_valid",   id_valid,      32'd0);

        // Decode backpressure: four issues fill the queue
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("bp0_req_valid", imem_req_valid, 32'd1);
        tick();
        tick();
        tick();
        tick();
        chk("bp_full_req_valid",  imem_req_valid, 32'd0);
        chk("bp_full_pc_advance", pc_advance,     32'd0);
        chk("bp_full_req_addr",   imem_req_addr,  32'h20);
        chk("bp_full_id_pc",      id_pc,          32'h10);
        tick();
        chk("bp_hold_req_valid",  imem_req_valid, 32'd0);
        chk("bp_hold_req_addr",   imem_req_addr,  32'h20);
        chk("bp_hold_id_pc",      id_pc,          32'h10);
        id_ready = 1'b1;
        #1;
        chk("dr0_req_valid", imem_req_valid, 32'd0);
        chk("dr0_id_instr",  id_instr,       32'hC0DE_0010);
        tick();
        chk("dr1_req_valid", imem_req_valid, 32'd1);
        chk("dr1_req_addr",  imem_req_addr,  32'h20);
        chk("dr1_id_pc",     id_pc,          32'h14);
        tick();
        chk("dr2_id_pc",     id_pc,          32'h18);
        tick();
        chk("dr3_id_pc",     id_pc,          32'h1C);
        tick();
        chk("dr4_id_pc",     id_pc,          32'h20);
        chk("dr4_id_instr",  id_instr,       32'hC0DE_0020);

        imem_req_ready = 1'b0;
        repeat (6) tick();
        chk("drain1_id_valid", id_valid, 32'd0);

        // Flush with two requests in flight on a 3-cycle memory
        lat            = 2'd3;
        imem_req_ready = 1'b1;
        #1;
        chk("fl0_req_addr", imem_req_addr, 32'h2C);
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flF_req_valid",  imem_req_valid, 32'd0);
        chk("flF_pc_advance", pc_advance,     32'd0);
        chk("flF_id_valid",   id_valid,       32'd0);
        tick();
        flush      = 1'b0;
        pc_address = 32'h100;
        #1;
        chk("fl1_req_valid", imem_req_valid, 32'd0);
        chk("fl1_rsp_seen",  imem_rsp_valid, 32'd1);
        chk("fl1_id_valid",  id_valid,       32'd0);
        tick();
        chk("fl2_req_valid", imem_req_valid, 32'd0);
        chk("fl2_id_valid",  id_valid,       32'd0);
        tick();
        chk("fl3_req_valid", imem_req_valid, 32'd1);
        chk("fl3_req_addr",  imem_req_addr,  32'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_wait_id_valid", id_valid, 32'd0);
        end
        tick();
        chk("fl_first_id_valid", id_valid, 32'd1);
        chk("fl_first_id_pc",    id_pc,    32'h100);
        chk("fl_first_id_instr", id_instr, 32'hC0DE_0100);

        imem_req_ready = 1'b0;
        repeat (8) tick();
        chk("drain2_id_valid", id_valid, 32'd0);

        // Flush coinciding with the only outstanding response
        lat            = 2'd1;
        imem_req_ready = 1'b1;
        #1;
        chk("fc0_req_addr", imem_req_addr, 32'h110);
        tick();
        flush = 1'b1;
        #1;
        chk("fcF_rsp_seen",  imem_rsp_valid, 32'd1);
        chk("fcF_req_valid", imem_req_valid, 32'd0);
        chk("fcF_id_valid",  id_valid,       32'd0);
        tick();
        flush      = 1'b0;
        pc_address = 32'h200;
        #1;
        chk("fc1_req_valid",  imem_req_valid, 32'd1);
        chk("fc1_pc_advance", pc_advance,     32'd1);
        chk("fc1_req_addr",   imem_req_addr,  32'h200);
        chk("fc1_id_valid",   id_valid,       32'd0);
        tick();
        tick();
        chk("fc3_id_pc",    id_pc,    32'h200);
        chk("fc3_id_instr", id_instr, 32'hC0DE_0200);
        tick();
        chk("ar_pre_id_valid", id_valid, 32'd1);
        chk("ar_pre_id_pc",    id_pc,    32'h204);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_id_valid",   id_valid,       32'd0);
        chk("ar_req_valid",  imem_req_valid, 32'd0);
        chk("ar_pc_advance", pc_advance,     32'd0);
        chk("ar_id_pc",      id_pc,          32'd0);
        mem_clear();
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_rel_req_valid", imem_req_valid, 32'd1);
        chk("ar_rel_req_addr",  imem_req_addr,  32'h20C);
        chk("ar_rel_id_valid",  id_valid,       32'd0);
        tick();
        chk("ar_r1_id_valid", id_valid, 32'd0);
        tick();
        chk("ar_r2_id_valid", id_valid, 32'd1);
        chk("ar_r2_id_pc",    id_pc,    32'h20C);
        chk("ar_r2_id_instr", id_instr, 32'hC0DE_020C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
